// File: rtl/accum58_pkg.sv
// Shared widths and FSM state encoding for the accum58 sequencer.
package accum58_pkg;
  localparam int unsigned ACC_W  = 58;
  localparam int unsigned TERM_W = 27;
  localparam int unsigned RES_W  = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/accum58_add.sv
// Combinational 58-bit + zero-extended 27-bit adder; sum_c[ACC_W] is the carry out.
module accum58_add
  import accum58_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [TERM_W-1:0] term,
  output logic [ACC_W:0]    sum_c
);
  assign sum_c = (ACC_W+1)'(acc) + (ACC_W+1)'(term);
endmodule

// File: rtl/accum58_sequencer.sv
// Job sequencer: loads an initial value, accumulates num_terms streamed terms, hands off {ovf, acc}.
// Define ACCUM58_SAT_EN to clamp the accumulator at all-ones on overflow instead of wrapping.
module accum58_sequencer
  import accum58_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic [ACC_W-1:0]  init_acc,
  input  logic              term_valid,
  input  logic [TERM_W-1:0] term_data,
  output logic              term_ready,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  result
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W:0]     sum_c;

  accum58_add u_add (
    .acc   (acc_q),
    .term  (term_data),
    .sum_c (sum_c)
  );

  // State register plus datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = init_acc;
          ovf_d   = 1'b0;
          cnt_d   = num_terms;
          state_d = (num_terms == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (term_valid) begin
          cnt_d = cnt_q - CNT_W'(1);
          ovf_d = ovf_q | sum_c[ACC_W];
`ifdef ACCUM58_SAT_EN
          // Once clamped, stay pinned at all-ones for the rest of the job
          acc_d = (sum_c[ACC_W] || ovf_q) ? '1 : sum_c[ACC_W-1:0];
`else
          acc_d = sum_c[ACC_W-1:0];
`endif
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decode the state register only
  assign term_ready = (state_q == ACCUM);
  assign busy       = (state_q != IDLE);
  assign res_valid  = (state_q == DONE);
  assign result     = {ovf_q, acc_q};

endmodule

// File: tb/tb_accum58_sequencer.sv
// Directed self-checking bench for accum58_sequencer (honours ACCUM58_SAT_EN in expectations).
module tb_accum58_sequencer;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  num_terms;
  logic [57:0] init_acc;
  logic        term_valid;
  logic [26:0] term_data;
  logic        term_ready;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [58:0] result;

  int tests;
  int failures;
  logic [58:0] exp_res;
  logic [57:0] ones58;

  accum58_sequencer #(.CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_terms  (num_terms),
    .init_acc   (init_acc),
    .term_valid (term_valid),
    .term_data  (term_data),
    .term_ready (term_ready),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic tr, input logic bz, input logic rv);
    check({tag, "_term_ready"}, 64'(term_ready), 64'(tr));
    check({tag, "_busy"},       64'(busy),       64'(bz));
    check({tag, "_res_valid"},  64'(res_valid),  64'(rv));
  endtask

  initial begin
    tests = 0;
    failures = 0;
    ones58 = '1;
    rst_n = 1'b0;
    start = 1'b0;
    num_terms = '0;
    init_acc = '0;
    term_valid = 1'b0;
    term_data = '0;
    res_ready = 1'b0;

    // Reset state
    #3;
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset_result", 64'(result), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_flags("idle", 1'b0, 1'b0, 1'b0);

    // Job: 0 + 5 + 7 + 9 back-to-back
    start = 1'b1; num_terms = 5'd3; init_acc = 58'd0;
    tick();
    start = 1'b0;
    check_flags("j1_accum", 1'b1, 1'b1, 1'b0);
    term_valid = 1'b1; term_data = 27'd5;
    tick();
    check("j1_ready2", 64'(term_ready), 64'd1);
    term_data = 27'd7;
    tick();
    check("j1_ready3", 64'(term_ready), 64'd1);
    term_data = 27'd9;
    tick();
    term_valid = 1'b0;
    check_flags("j1_done", 1'b0, 1'b1, 1'b1);
    check("j1_result", 64'(result), 64'd21);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_flags("j1_idle", 1'b0, 1'b0, 1'b0);

    // Zero-term job goes straight to DONE
    start = 1'b1; num_terms = 5'd0; init_acc = 58'h123;
    tick();
    start = 1'b0;
    check_flags("j2_done", 1'b0, 1'b1, 1'b1);
    check("j2_result", 64'(result), 64'h123);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_flags("j2_idle", 1'b0, 1'b0, 1'b0);

    // Overflow on max init + 2
    start = 1'b1; num_terms = 5'd1; init_acc = ones58;
    tick();
    start = 1'b0;
    term_valid = 1'b1; term_data = 27'd2;
    tick();
    term_valid = 1'b0;
`ifdef ACCUM58_SAT_EN
    exp_res = {1'b1, ones58};
`else
    exp_res = {1'b1, 58'd1};
`endif
    check_flags("j3_done", 1'b0, 1'b1, 1'b1);
    check("j3_result", 64'(result), 64'(exp_res));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Gapped terms, ignored start pulses, delayed res_ready
    start = 1'b1; num_terms = 5'd2; init_acc = 58'd0;
    tick();
    start = 1'b0;
    term_valid = 1'b1; term_data = 27'd1;
    tick();
    term_valid = 1'b0;
    start = 1'b1; num_terms = 5'd1; init_acc = 58'd77;
    tick();
    check_flags("j4_gap1", 1'b1, 1'b1, 1'b0);
    tick();
    check_flags("j4_gap2", 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    term_valid = 1'b1; term_data = 27'd4;
    tick();
    term_valid = 1'b0;
    check("j4_result", 64'(result), 64'd5);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; num_terms = 5'd3; init_acc = 58'd99;
      tick();
      check("j4_hold_valid", 64'(res_valid), 64'd1);
      check("j4_hold_result", 64'(result), 64'd5);
    end
    start = 1'b1; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_flags("j4_idle", 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    check_flags("j4_still_idle", 1'b0, 1'b0, 1'b0);

    // Reset mid-job after 2 of 4 terms (ovf already set)
    start = 1'b1; num_terms = 5'd4; init_acc = ones58;
    tick();
    start = 1'b0;
    term_valid = 1'b1; term_data = 27'd1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_flags("j5_reset", 1'b0, 1'b0, 1'b0);
    check("j5_reset_result", 64'(result), 64'd0);
    tick();
    term_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check_flags("j5_after", 1'b0, 1'b0, 1'b0);

    // Fresh job after reset: 10 + 1 + 1, no stale ovf
    start = 1'b1; num_terms = 5'd2; init_acc = 58'd10;
    tick();
    start = 1'b0;
    term_valid = 1'b1; term_data = 27'd1;
    tick();
    tick();
    term_valid = 1'b0;
    check_flags("j6_done", 1'b0, 1'b1, 1'b1);
    check("j6_result", 64'(result), 64'd12);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_flags("j6_idle", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/accum58_sequencer.md
ACCUM58_SEQUENCER -- requirements
Module: accum58_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 5, width of the term counter (max 2^CNT_W-1 terms per job).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-005 SHALL have port num_terms  input  CNT_W  number of terms in job; sampled with start.
REQ-006 SHALL have port init_acc  input  58  initial accumulator value; sampled with start.
REQ-007 SHALL have port term_valid  input  1  term_data valid.
REQ-008 SHALL have port term_data  input  27  unsigned term, zero-extended to 58 bits before adding.
REQ-009 SHALL have port term_ready  output  1  block accepts a term this cycle.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port res_valid  output  1  result available.
REQ-012 SHALL have port res_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  59  {ovf, acc[57:0]}.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 IDLE: start=1 with num_terms!=0 SHALL load acc<=init_acc, ovf<=0, cnt<=num_terms, go ACCUM.
REQ-016 IDLE: start=1 with num_terms==0 SHALL load acc<=init_acc, ovf<=0, go DONE directly.
REQ-017 start SHALL be ignored in ACCUM and DONE; no queuing.
REQ-018 term_ready SHALL be 1 exactly in ACCUM (combinational from state only, not from term_valid).
REQ-019 A term SHALL be accepted on a cycle with term_valid and term_ready both 1; acc<=acc+{31'b0,term_data}, cnt<=cnt-1.
REQ-020 Throughput SHALL be one term per cycle; no bubbles between back-to-back terms.
REQ-021 Acceptance with cnt==1 SHALL move to DONE; res_valid SHALL rise the next cycle (latency 1 from last term).
REQ-022 Carry out of bit 57 on any add SHALL set sticky ovf; default behaviour wraps acc modulo 2^58.
REQ-023 DONE: res_valid=1, result={ovf,acc} SHALL hold stable until res_ready=1; then go IDLE next cycle.
REQ-024 res_valid and res_ready both 1 in DONE with start=1 SHALL NOT start a new job that cycle; start is honoured only from IDLE.
REQ-025 result SHALL read {ovf,acc} in all states; meaningful only while res_valid=1.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, acc=0, ovf=0, cnt=0; outputs term_ready=0, busy=0, res_valid=0, result=0.
REQ-027 Reset mid-job SHALL discard the job; terms in flight are dropped, no result is produced.
REQ-028 Reset deassertion SHALL be assumed synchronous to clk by the integrator; block takes no start before first clk edge.

Configuration
REQ-029 Macro ACCUM58_SAT_EN defined: on carry out, acc SHALL clamp to 58'h3FF_FFFF_FFFF_FFFF (all ones) and remain there for the rest of the job; ovf set.
REQ-030 Macro ACCUM58_SAT_EN undefined: acc SHALL wrap per REQ-022; ovf set identically.

Structure
REQ-031 Shared package accum58_pkg SHALL hold ACC_W=58, TERM_W=27, RES_W=59, and the FSM state enum.
REQ-032 Addition SHALL be in one sub-module accum58_add (58-bit + 27-bit zero-extended -> 59-bit sum), purely combinational; FSM, counter, saturation in top.

Verification
REQ-033 Job init_acc=0, num_terms=3, terms 5,7,9 back-to-back -> term_ready 3 cycles, res_valid next cycle, result=59'd21.
REQ-034 num_terms=0, init_acc=58'h123 -> DONE one cycle after start, result=59'h123, term_ready never 1.
REQ-035 init_acc=2^58-1, one term 2 -> result ovf=1, acc=1 (no SAT) / acc=2^58-1 (SAT_EN).
REQ-036 term_valid gaps (terms 1,_,_,4 with 2 idle cycles), res_ready held 0 for 5 cycles -> result=5 held stable, start pulses ignored, IDLE after res_ready.
REQ-037 rst_n asserted after 2 of 4 terms -> all outputs 0 asynchronously; next job init_acc=10, terms 1,1 -> result=12, no stale ovf.
